// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester arbiter in front of a single-port data memory.
// The core pipeline normally wins; an aux master (loader/debug) is granted when
// the core is idle, when it has been denied MP_STARVE_MAX cycles in a row, or
// for every cycle of a locked burst.
//
// Handshake: a request is a level held on *_req for as long as the requester
// wants the bus. *_gnt is combinational in the same cycle, and an access is
// performed exactly in a cycle where req and gnt are both high. Read data
// returns one cycle later with a single-cycle *_rvalid pulse. There is no
// back-pressure on the read response.
module dmem_arbiter #(
  parameter int MP_DATA_WIDTH = 32,
  parameter int MP_ADDR_WIDTH = 32,
  parameter int MP_STARVE_MAX = 4
) (
  input  logic                     iclk,
  input  logic                     irst,
  // core port
  input  logic                     icore_req,
  input  logic                     icore_wen,
  input  logic [MP_ADDR_WIDTH-1:0] icore_addr,
  input  logic [MP_DATA_WIDTH-1:0] icore_wdata,
  input  logic [1:0]               icore_be,
  output logic                     ocore_gnt,
  output logic                     ocore_stall,
  output logic [MP_DATA_WIDTH-1:0] ocore_rdata,
  output logic                     ocore_rvalid,
  // aux port
  input  logic                     iaux_req,
  input  logic                     iaux_wen,
  input  logic                     iaux_lock,
  input  logic [MP_ADDR_WIDTH-1:0] iaux_addr,
  input  logic [MP_DATA_WIDTH-1:0] iaux_wdata,
  input  logic [1:0]               iaux_be,
  output logic                     oaux_gnt,
  output logic [MP_DATA_WIDTH-1:0] oaux_rdata,
  output logic                     oaux_rvalid,
  // data memory port
  output logic [MP_ADDR_WIDTH-1:0] omem_addr,
  output logic [MP_DATA_WIDTH-1:0] omem_wdata,
  output logic                     omem_wen,
  output logic [1:0]               omem_be,
  input  logic [MP_DATA_WIDTH-1:0] imem_rdata,
  // debug visibility of arbiter state (0 = ARB, 1 = AUX_LOCK)
  output logic                     odbg_state,
  output logic [3:0]               odbg_starve_cnt
);

  typedef enum logic {
    ST_ARB      = 1'b0,
    ST_AUX_LOCK = 1'b1
  } state_t;

  localparam logic [3:0] LP_STARVE_MAX = 4'(MP_STARVE_MAX);

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [3:0]               r_starve_cnt;
  logic [3:0]               w_starve_nxt;
  logic                     w_lock_hold;
  logic                     w_core_gnt;
  logic                     w_aux_gnt;
  logic [MP_DATA_WIDTH-1:0] r_core_rdata;
  logic                     r_core_rvalid;
  logic [MP_DATA_WIDTH-1:0] r_aux_rdata;
  logic                     r_aux_rvalid;

  // A locked burst continues only while aux keeps both req and lock high;
  // the cycle either drops is arbitrated normally.
  assign w_lock_hold = (r_state == ST_AUX_LOCK) && iaux_req && iaux_lock;

  // Grant decision; all grants are suppressed while reset is asserted.
  always_comb begin
    w_core_gnt = 1'b0;
    w_aux_gnt  = 1'b0;
    if (irst) begin
      if (w_lock_hold) begin
        w_aux_gnt = 1'b1;
      end else if (icore_req && iaux_req) begin
        if (r_starve_cnt == LP_STARVE_MAX) begin
          w_aux_gnt = 1'b1;
        end else begin
          w_core_gnt = 1'b1;
        end
      end else if (icore_req) begin
        w_core_gnt = 1'b1;
      end else if (iaux_req) begin
        w_aux_gnt = 1'b1;
      end
    end
  end

  // Next-state and starvation counter update.
  always_comb begin
    w_state_nxt  = r_state;
    w_starve_nxt = 4'd0;
    case (r_state)
      ST_ARB: begin
        if (w_aux_gnt && iaux_lock) begin
          w_state_nxt = ST_AUX_LOCK;
        end
      end
      ST_AUX_LOCK: begin
        if (!w_lock_hold) begin
          w_state_nxt = ST_ARB;
        end
      end
      default: begin
        w_state_nxt = ST_ARB;
      end
    endcase
    // Count consecutive denied aux cycles; any grant or idle aux clears it.
    if (!w_lock_hold && iaux_req && !w_aux_gnt) begin
      if (r_starve_cnt < LP_STARVE_MAX) begin
        w_starve_nxt = r_starve_cnt + 4'd1;
      end else begin
        w_starve_nxt = r_starve_cnt;
      end
    end
  end

  // Arbiter state registers.
  always_ff @(posedge iclk or negedge irst) begin
    if (!irst) begin
      r_state      <= ST_ARB;
      r_starve_cnt <= 4'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_starve_cnt <= w_starve_nxt;
    end
  end

  // Capture read data for the requester granted a read this cycle.
  always_ff @(posedge iclk or negedge irst) begin
    if (!irst) begin
      r_core_rdata  <= '0;
      r_core_rvalid <= 1'b0;
      r_aux_rdata   <= '0;
      r_aux_rvalid  <= 1'b0;
    end else begin
      r_core_rvalid <= w_core_gnt && !icore_wen;
      r_aux_rvalid  <= w_aux_gnt && !iaux_wen;
      if (w_core_gnt && !icore_wen) begin
        r_core_rdata <= imem_rdata;
      end
      if (w_aux_gnt && !iaux_wen) begin
        r_aux_rdata <= imem_rdata;
      end
    end
  end

  // Memory-side mux: aux fields when aux owns the bus, otherwise core fields.
  always_comb begin
    omem_addr  = icore_addr;
    omem_wdata = icore_wdata;
    omem_be    = icore_be;
    if (w_aux_gnt) begin
      omem_addr  = iaux_addr;
      omem_wdata = iaux_wdata;
      omem_be    = iaux_be;
    end
  end

  assign omem_wen        = (w_core_gnt && icore_wen) || (w_aux_gnt && iaux_wen);
  assign ocore_gnt       = w_core_gnt;
  assign oaux_gnt        = w_aux_gnt;
  assign ocore_stall     = icore_req && !w_core_gnt && irst;
  assign ocore_rdata     = r_core_rdata;
  assign ocore_rvalid    = r_core_rvalid;
  assign oaux_rdata      = r_aux_rdata;
  assign oaux_rvalid     = r_aux_rvalid;
  assign odbg_state      = r_state;
  assign odbg_starve_cnt = r_starve_cnt;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with hand-computed expectations.
module tb_dmem_arbiter;

  localparam int DW = 32;
  localparam int AW = 32;

  // clock / reset
  logic iclk = 1'b0;
  logic irst;
  always #5 iclk = ~iclk;

  logic          icore_req, icore_wen;
  logic [AW-1:0] icore_addr;
  logic [DW-1:0] icore_wdata;
  logic [1:0]    icore_be;
  logic          ocore_gnt, ocore_stall, ocore_rvalid;
  logic [DW-1:0] ocore_rdata;
  logic          iaux_req, iaux_wen, iaux_lock;
  logic [AW-1:0] iaux_addr;
  logic [DW-1:0] iaux_wdata;
  logic [1:0]    iaux_be;
  logic          oaux_gnt, oaux_rvalid;
  logic [DW-1:0] oaux_rdata;
  logic [AW-1:0] omem_addr;
  logic [DW-1:0] omem_wdata;
  logic          omem_wen;
  logic [1:0]    omem_be;
  logic [DW-1:0] imem_rdata;
  logic          odbg_state;
  logic [3:0]    odbg_starve_cnt;

  dmem_arbiter #(.MP_DATA_WIDTH(DW), .MP_ADDR_WIDTH(AW), .MP_STARVE_MAX(4)) dut (
    .iclk(iclk), .irst(irst),
    .icore_req(icore_req), .icore_wen(icore_wen), .icore_addr(icore_addr),
    .icore_wdata(icore_wdata), .icore_be(icore_be),
    .ocore_gnt(ocore_gnt), .ocore_stall(ocore_stall),
    .ocore_rdata(ocore_rdata), .ocore_rvalid(ocore_rvalid),
    .iaux_req(iaux_req), .iaux_wen(iaux_wen), .iaux_lock(iaux_lock),
    .iaux_addr(iaux_addr), .iaux_wdata(iaux_wdata), .iaux_be(iaux_be),
    .oaux_gnt(oaux_gnt), .oaux_rdata(oaux_rdata), .oaux_rvalid(oaux_rvalid),
    .omem_addr(omem_addr), .omem_wdata(omem_wdata), .omem_wen(omem_wen),
    .omem_be(omem_be), .imem_rdata(imem_rdata),
    .odbg_state(odbg_state), .odbg_starve_cnt(odbg_starve_cnt)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  // driver tasks
  task automatic drive_core(input logic req, input logic wen, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wdata, input logic [1:0] be);
    icore_req = req; icore_wen = wen; icore_addr = addr; icore_wdata = wdata; icore_be = be;
  endtask

  task automatic drive_aux(input logic req, input logic wen, input logic lock,
                           input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                           input logic [1:0] be);
    iaux_req = req; iaux_wen = wen; iaux_lock = lock; iaux_addr = addr;
    iaux_wdata = wdata; iaux_be = be;
  endtask

  task automatic drive_idle();
    drive_core(1'b0, 1'b0, '0, '0, 2'b00);
    drive_aux(1'b0, 1'b0, 1'b0, '0, '0, 2'b00);
    imem_rdata = '0;
  endtask

  // advance to just after the next rising edge
  task automatic next_cycle();
    @(posedge iclk);
    #1;
  endtask

  initial begin
    logic exp_core, exp_aux;
    // ---------------- reset with requests pending ----------------
    irst = 1'b0;
    drive_core(1'b1, 1'b1, 32'h4, 32'h1, 2'b10);
    drive_aux(1'b1, 1'b1, 1'b0, 32'h8, 32'h2, 2'b10);
    imem_rdata = 32'hFFFF_FFFF;
    #3;
    check_eq("rst_core_gnt", ocore_gnt, 0);
    check_eq("rst_aux_gnt", oaux_gnt, 0);
    check_eq("rst_stall", ocore_stall, 0);
    check_eq("rst_mem_wen", omem_wen, 0);
    check_eq("rst_core_rvalid", ocore_rvalid, 0);
    check_eq("rst_aux_rvalid", oaux_rvalid, 0);
    check_eq("rst_core_rdata", ocore_rdata, 0);
    check_eq("rst_aux_rdata", oaux_rdata, 0);
    check_eq("rst_state", odbg_state, 0);
    check_eq("rst_starve", odbg_starve_cnt, 0);
    next_cycle();
    drive_idle();
    irst = 1'b1;
    next_cycle();

    // ---------------- single core read ----------------
    drive_core(1'b1, 1'b0, 32'h10, 32'h0, 2'b10);
    imem_rdata = 32'hDEAD_BEEF;
    #1;
    check_eq("rd_core_gnt", ocore_gnt, 1);
    check_eq("rd_aux_gnt", oaux_gnt, 0);
    check_eq("rd_stall", ocore_stall, 0);
    check_eq("rd_mem_addr", omem_addr, 32'h10);
    check_eq("rd_mem_wen", omem_wen, 0);
    next_cycle();
    drive_idle();
    check_eq("rd_rvalid", ocore_rvalid, 1);
    check_eq("rd_rdata", ocore_rdata, 32'hDEAD_BEEF);
    next_cycle();
    check_eq("rd_rvalid_pulse", ocore_rvalid, 0);
    check_eq("rd_rdata_hold", ocore_rdata, 32'hDEAD_BEEF);

    // ---------------- back-to-back core reads ----------------
    drive_core(1'b1, 1'b0, 32'h4, 32'h0, 2'b10);
    imem_rdata = 32'h1111_0004;
    next_cycle();
    drive_core(1'b1, 1'b0, 32'h8, 32'h0, 2'b10);
    imem_rdata = 32'h2222_0008;
    check_eq("b2b_rvalid0", ocore_rvalid, 1);
    check_eq("b2b_rdata0", ocore_rdata, 32'h1111_0004);
    #1;
    check_eq("b2b_mem_addr1", omem_addr, 32'h8);
    next_cycle();
    // core write follows: no rvalid for it, rdata keeps last read value
    drive_core(1'b1, 1'b1, 32'hC, 32'hCAFE_F00D, 2'b01);
    imem_rdata = 32'h3333_3333;
    check_eq("b2b_rvalid1", ocore_rvalid, 1);
    check_eq("b2b_rdata1", ocore_rdata, 32'h2222_0008);
    #1;
    check_eq("cwr_mem_wen", omem_wen, 1);
    check_eq("cwr_mem_wdata", omem_wdata, 32'hCAFE_F00D);
    check_eq("cwr_mem_be", omem_be, 2'b01);
    next_cycle();
    drive_idle();
    check_eq("cwr_no_rvalid", ocore_rvalid, 0);
    check_eq("cwr_rdata_hold", ocore_rdata, 32'h2222_0008);
    next_cycle();

    // ---------------- aux write, core idle ----------------
    drive_aux(1'b1, 1'b1, 1'b0, 32'h20, 32'h1234_5678, 2'b10);
    #1;
    check_eq("awr_aux_gnt", oaux_gnt, 1);
    check_eq("awr_core_gnt", ocore_gnt, 0);
    check_eq("awr_mem_wen", omem_wen, 1);
    check_eq("awr_mem_addr", omem_addr, 32'h20);
    check_eq("awr_mem_be", omem_be, 2'b10);
    check_eq("awr_mem_wdata", omem_wdata, 32'h1234_5678);
    next_cycle();
    // reserved size code passes straight through
    drive_aux(1'b1, 1'b1, 1'b0, 32'h21, 32'h0000_00AA, 2'b11);
    check_eq("awr_no_rvalid", oaux_rvalid, 0);
    #1;
    check_eq("be11_pass", omem_be, 2'b11);
    next_cycle();
    drive_idle();
    next_cycle();

    // ---------------- fairness: both request reads continuously ----------------
    drive_core(1'b1, 1'b0, 32'h100, 32'h0, 2'b10);
    drive_aux(1'b1, 1'b0, 1'b0, 32'h200, 32'h0, 2'b10);
    for (int i = 0; i < 10; i++) begin
      exp_aux  = ((i % 5) == 4);
      exp_core = !exp_aux;
      imem_rdata = 32'hA000_0000 + i;
      #1;
      check_eq($sformatf("fair_core_gnt_%0d", i), ocore_gnt, exp_core);
      check_eq($sformatf("fair_aux_gnt_%0d", i), oaux_gnt, exp_aux);
      check_eq($sformatf("fair_stall_%0d", i), ocore_stall, exp_aux);
      check_eq($sformatf("fair_starve_%0d", i), odbg_starve_cnt, i % 5);
      next_cycle();
      check_eq($sformatf("fair_core_rv_%0d", i), ocore_rvalid, exp_core);
      check_eq($sformatf("fair_aux_rv_%0d", i), oaux_rvalid, exp_aux);
      if (exp_aux) check_eq($sformatf("fair_aux_rd_%0d", i), oaux_rdata, 32'hA000_0000 + i);
    end
    // aux drops for one cycle: counter clears even below the limit
    drive_idle();
    drive_core(1'b1, 1'b0, 32'h100, 32'h0, 2'b10);
    next_cycle();
    drive_idle();
    check_eq("starve_clear", odbg_starve_cnt, 0);
    next_cycle();

    // ---------------- locked aux burst while core requests ----------------
    drive_core(1'b1, 1'b0, 32'h300, 32'h0, 2'b10);
    drive_aux(1'b1, 1'b1, 1'b1, 32'h40, 32'h5555_AAAA, 2'b10);
    for (int i = 0; i < 7; i++) begin
      exp_aux = (i >= 4);
      #1;
      check_eq($sformatf("lock_aux_gnt_%0d", i), oaux_gnt, exp_aux);
      check_eq($sformatf("lock_core_gnt_%0d", i), ocore_gnt, !exp_aux);
      check_eq($sformatf("lock_stall_%0d", i), ocore_stall, exp_aux);
      if (exp_aux) begin
        check_eq($sformatf("lock_mem_wen_%0d", i), omem_wen, 1);
        check_eq($sformatf("lock_mem_addr_%0d", i), omem_addr, 32'h40);
      end
      next_cycle();
      if (exp_aux) begin
        check_eq($sformatf("lock_state_%0d", i), odbg_state, 1);
        check_eq($sformatf("lock_starve_%0d", i), odbg_starve_cnt, 0);
        check_eq($sformatf("lock_no_rvalid_%0d", i), oaux_rvalid, 0);
      end
    end
    // lock drops with aux still requesting: arbitrated normally, core wins
    iaux_lock = 1'b0;
    #1;
    check_eq("unlock_core_gnt", ocore_gnt, 1);
    check_eq("unlock_aux_gnt", oaux_gnt, 0);
    next_cycle();
    check_eq("unlock_state", odbg_state, 0);
    check_eq("unlock_starve", odbg_starve_cnt, 1);
    drive_idle();
    next_cycle();

    // ---------------- reset the cycle after a core read grant ----------------
    drive_core(1'b1, 1'b0, 32'h10, 32'h0, 2'b10);
    imem_rdata = 32'h0BAD_CAFE;
    next_cycle();
    check_eq("rrd_rvalid_pre", ocore_rvalid, 1);
    irst = 1'b0;
    #1;
    check_eq("rrd_rvalid", ocore_rvalid, 0);
    check_eq("rrd_rdata", ocore_rdata, 0);
    check_eq("rrd_core_gnt", ocore_gnt, 0);
    check_eq("rrd_stall", ocore_stall, 0);
    check_eq("rrd_state", odbg_state, 0);
    check_eq("rrd_starve", odbg_starve_cnt, 0);
    next_cycle();
    drive_idle();
    irst = 1'b1;
    next_cycle();

    // ---------------- reset in the middle of a locked burst ----------------
    drive_aux(1'b1, 1'b0, 1'b1, 32'h60, 32'h0, 2'b10);
    imem_rdata = 32'h7777_0060;
    next_cycle();
    check_eq("mlk_state_pre", odbg_state, 1);
    check_eq("mlk_rvalid_pre", oaux_rvalid, 1);
    drive_aux(1'b1, 1'b1, 1'b1, 32'h64, 32'h9, 2'b10);
    drive_core(1'b1, 1'b1, 32'h68, 32'h9, 2'b10);
    irst = 1'b0;
    #1;
    check_eq("mlk_state", odbg_state, 0);
    check_eq("mlk_aux_rvalid", oaux_rvalid, 0);
    check_eq("mlk_aux_rdata", oaux_rdata, 0);
    check_eq("mlk_aux_gnt", oaux_gnt, 0);
    check_eq("mlk_core_gnt", ocore_gnt, 0);
    check_eq("mlk_mem_wen", omem_wen, 0);
    next_cycle();
    // release away from the edge: first rising edge with reset high arbitrates
    drive_idle();
    drive_core(1'b1, 1'b0, 32'h70, 32'h0, 2'b10);
    imem_rdata = 32'h0000_0070;
    irst = 1'b1;
    #1;
    check_eq("rel_core_gnt", ocore_gnt, 1);
    next_cycle();
    drive_idle();
    check_eq("rel_rvalid", ocore_rvalid, 1);
    check_eq("rel_rdata", ocore_rdata, 32'h0000_0070);
    next_cycle();

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter MP_DATA_WIDTH, default 32, data word width.
REQ-002 SHALL have parameter MP_ADDR_WIDTH, default 32, byte address width.
REQ-003 SHALL have parameter MP_STARVE_MAX, default 4, consecutive aux denials that force an aux grant (range 1..15).
REQ-004 iclk  input  1  sole clock, all state on rising edge.
REQ-005 irst  input  1  reset, asynchronous, active-low.
REQ-006 icore_req  input  1  core (pipeline M stage) requests access this cycle.
REQ-007 icore_wen  input  1  core write (1) / read (0).
REQ-008 icore_addr  input  MP_ADDR_WIDTH  core byte address.
REQ-009 icore_wdata  input  MP_DATA_WIDTH  core write data.
REQ-010 icore_be  input  2  core access size: 00 byte, 01 half, 10 word, 11 reserved.
REQ-011 ocore_gnt  output  1  core access performed this cycle.
REQ-012 ocore_stall  output  1  core request pending but not granted; pipeline holds M stage.
REQ-013 ocore_rdata  output  MP_DATA_WIDTH  registered core read data.
REQ-014 ocore_rvalid  output  1  ocore_rdata valid, one-cycle pulse.
REQ-015 iaux_req, iaux_wen, iaux_lock  input  1 each  aux (loader/debug) request, write, bus-lock.
REQ-016 iaux_addr / iaux_wdata / iaux_be  input  MP_ADDR_WIDTH / MP_DATA_WIDTH / 2  aux address, data, size.
REQ-017 oaux_gnt, oaux_rvalid  output  1 each; oaux_rdata  output  MP_DATA_WIDTH  aux grant and registered read response.
REQ-018 omem_addr / omem_wdata  output  MP_ADDR_WIDTH / MP_DATA_WIDTH; omem_wen  output  1; omem_be  output  2  to data memory.
REQ-019 imem_rdata  input  MP_DATA_WIDTH  combinational read data from data memory.

Function
REQ-020 SHALL implement FSM states ARB and AUX_LOCK, plus a starvation counter starve_cnt (4 bits).
REQ-021 At most one of ocore_gnt, oaux_gnt SHALL be high in any cycle; grants are combinational from requests and current state.
REQ-022 In ARB: core-only request -> core granted; aux-only -> aux granted; both -> core granted unless starve_cnt == MP_STARVE_MAX, then aux granted.
REQ-023 starve_cnt SHALL increment (saturating at MP_STARVE_MAX) on each cycle iaux_req is high and aux not granted, and clear to 0 on any aux grant or cycle with iaux_req low.
REQ-024 ARB -> AUX_LOCK when aux granted with iaux_lock=1; AUX_LOCK -> ARB on the first cycle iaux_req=0 or iaux_lock=0 (that cycle is arbitrated as ARB).
REQ-025 In AUX_LOCK, aux SHALL be granted every cycle regardless of core requests; starve_cnt held at 0.
REQ-026 ocore_stall SHALL equal icore_req & ~ocore_gnt.
REQ-027 omem_addr/wdata/be SHALL mux from the granted requester; omem_wen = granted requester's wen & grant; with no grant, omem_wen=0 and remaining mem outputs are don't-care.
REQ-028 A granted read SHALL capture imem_rdata at that clock edge into the requester's rdata register and pulse its rvalid for exactly the following cycle (latency 1).
REQ-029 Granted writes SHALL produce no rvalid; rdata registers hold value until the next granted read of that requester.
REQ-030 Back-to-back reads by the same requester SHALL yield rvalid high on consecutive cycles with correct per-cycle data.
REQ-031 icore_be / iaux_be SHALL pass through unmodified, including 11; no address alignment checks in this block.

Reset
REQ-032 irst low SHALL immediately force state=ARB, starve_cnt=0, ocore_rvalid=0, oaux_rvalid=0, ocore_rdata=0, oaux_rdata=0.
REQ-033 While irst low, ocore_gnt, oaux_gnt, ocore_stall and omem_wen SHALL be 0 regardless of requests.
REQ-034 Reset asserted mid-lock or with a read in flight SHALL drop the pending rvalid; no write issues from the reset cycle.
REQ-035 First arbitration after irst release SHALL occur on the first rising edge with irst high.

Verification
REQ-036 Core read only, addr 0x10, mem returns 0xDEADBEEF -> ocore_gnt=1 same cycle, ocore_rvalid=1 next cycle, ocore_rdata=0xDEADBEEF.
REQ-037 Core and aux requesting continuously, MP_STARVE_MAX=4 -> core granted 4 cycles, aux granted cycle 5, ocore_stall=1 cycle 5, pattern repeats.
REQ-038 Aux write with iaux_lock=1 for 3 cycles while core requests -> oaux_gnt=1 and ocore_stall=1 for 3 cycles, then core granted when iaux_lock drops.
REQ-039 Aux write 0x12345678 to addr 0x20, be=10 -> omem_wen=1, omem_addr=0x20, omem_be=10, omem_wdata=0x12345678, no oaux_rvalid.
REQ-040 irst asserted the cycle after a core read grant -> ocore_rvalid=0 immediately, state ARB, starve_cnt=0, no grants while irst low.
